// File: rtl/trap_seq_ctrl.sv
// Decode-stage trap sequencer: drains older instructions, issues one CSR trap write
// or mret restore, then redirects fetch to mtvec/mepc and flushes ID.
module trap_seq_ctrl #(
  parameter logic [31:0] MCAUSE_ILLEGAL = 32'd2,
  parameter logic [31:0] MCAUSE_ECALL   = 32'd11,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_ir,
  input  logic             is_illegal_ir,
  input  logic             is_ecall,
  input  logic             is_mret,
  input  logic             older_inflight,
  input  logic             ex_redirect,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  output logic             stall_if_id,
  output logic             flush_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             csr_trap_we,
  output logic [31:0]      csr_mepc_wdata,
  output logic [31:0]      csr_mcause_wdata,
  output logic [31:0]      csr_mtval_wdata,
  output logic             csr_mret_we,
  output logic             busy,
  output logic [CNT_W-1:0] trap_cnt
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_ILL, K_ECALL, K_MRET} kind_t;

  state_t      state;
  kind_t       kind;
  logic [31:0] trap_pc;
  logic [31:0] trap_ir;
  logic        event_hit;

  function automatic kind_t decode_kind(input logic ill, input logic ecall);
    if (ill)        return K_ILL;
    else if (ecall) return K_ECALL;
    else            return K_MRET;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + 1'b1;
  endfunction

  // An event seen alongside an EX redirect is on the wrong path and is dropped.
  assign event_hit = id_valid && !ex_redirect && (is_illegal_ir || is_ecall || is_mret);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      kind     <= K_ILL;
      trap_pc  <= '0;
      trap_ir  <= '0;
      trap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (event_hit) begin
            trap_pc <= id_pc;
            trap_ir <= id_ir;
            kind    <= decode_kind(is_illegal_ir, is_ecall);
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (ex_redirect)         state <= IDLE;
          else if (!older_inflight) state <= COMMIT;
        end
        COMMIT: begin
          if (kind != K_MRET) trap_cnt <= sat_inc(trap_cnt);
          state <= REDIRECT;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; redirect_pc samples the CSRs live so
  // it reflects the write made during COMMIT.
  always_comb begin
    stall_if_id      = 1'b0;
    flush_id         = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    csr_trap_we      = 1'b0;
    csr_mepc_wdata   = '0;
    csr_mcause_wdata = '0;
    csr_mtval_wdata  = '0;
    csr_mret_we      = 1'b0;
    busy             = 1'b0;
    case (state)
      IDLE: stall_if_id = event_hit;
      DRAIN: begin
        stall_if_id = 1'b1;
        busy        = 1'b1;
        flush_id    = ex_redirect;
      end
      COMMIT: begin
        stall_if_id = 1'b1;
        busy        = 1'b1;
        if (kind == K_MRET) begin
          csr_mret_we = 1'b1;
        end else begin
          csr_trap_we      = 1'b1;
          csr_mepc_wdata   = trap_pc;
          csr_mcause_wdata = (kind == K_ILL) ? MCAUSE_ILLEGAL : MCAUSE_ECALL;
          csr_mtval_wdata  = (kind == K_ILL) ? trap_ir : 32'd0;
        end
      end
      REDIRECT: begin
        busy           = 1'b1;
        redirect_valid = 1'b1;
        flush_id       = 1'b1;
        redirect_pc    = (kind == K_MRET) ? (mepc & ~32'd3) : (mtvec & ~32'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Directed bench for trap_seq_ctrl; a second CNT_W=2 instance shares the stimulus
// to exercise counter saturation.
module tb_trap_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_ir;
  logic        is_illegal_ir, is_ecall, is_mret;
  logic        older_inflight, ex_redirect;
  logic [31:0] mtvec, mepc;

  logic        stall_if_id, flush_id, redirect_valid, csr_trap_we, csr_mret_we, busy;
  logic [31:0] redirect_pc, csr_mepc_wdata, csr_mcause_wdata, csr_mtval_wdata;
  logic [15:0] trap_cnt;

  logic        s_stall, s_flush, s_rv, s_twe, s_mwe, s_busy;
  logic [31:0] s_rpc, s_mepc, s_mcause, s_mtval;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trap_seq_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .is_illegal_ir(is_illegal_ir), .is_ecall(is_ecall), .is_mret(is_mret),
    .older_inflight(older_inflight), .ex_redirect(ex_redirect),
    .mtvec(mtvec), .mepc(mepc),
    .stall_if_id(stall_if_id), .flush_id(flush_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_trap_we(csr_trap_we), .csr_mepc_wdata(csr_mepc_wdata),
    .csr_mcause_wdata(csr_mcause_wdata), .csr_mtval_wdata(csr_mtval_wdata),
    .csr_mret_we(csr_mret_we), .busy(busy), .trap_cnt(trap_cnt)
  );

  trap_seq_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .is_illegal_ir(is_illegal_ir), .is_ecall(is_ecall), .is_mret(is_mret),
    .older_inflight(older_inflight), .ex_redirect(ex_redirect),
    .mtvec(mtvec), .mepc(mepc),
    .stall_if_id(s_stall), .flush_id(s_flush), .redirect_valid(s_rv),
    .redirect_pc(s_rpc), .csr_trap_we(s_twe), .csr_mepc_wdata(s_mepc),
    .csr_mcause_wdata(s_mcause), .csr_mtval_wdata(s_mtval),
    .csr_mret_we(s_mwe), .busy(s_busy), .trap_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; new inputs are applied 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic clear_id();
    id_valid = 0; is_illegal_ir = 0; is_ecall = 0; is_mret = 0;
    id_pc = 32'h0; id_ir = 32'h0;
  endtask

  task automatic fire(input logic ill, input logic ec, input logic mr,
                      input logic [31:0] pc, input logic [31:0] ir);
    id_valid = 1; is_illegal_ir = ill; is_ecall = ec; is_mret = mr;
    id_pc = pc; id_ir = ir;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, {31'd0, stall_if_id}, 32'd0);
    check({tag, "_flush"}, {31'd0, flush_id}, 32'd0);
    check({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
    check({tag, "_rpc"},   redirect_pc, 32'd0);
    check({tag, "_twe"},   {31'd0, csr_trap_we}, 32'd0);
    check({tag, "_wdata"}, csr_mepc_wdata | csr_mcause_wdata | csr_mtval_wdata, 32'd0);
    check({tag, "_mwe"},   {31'd0, csr_mret_we}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  // Simple trap with empty pipe: event, DRAIN, COMMIT, REDIRECT.
  task automatic quick_trap(input logic ill, input logic ec);
    fire(ill, ec, 1'b0, 32'h300, 32'h13);
    cyc(); clear_id();
    cyc(); cyc(); cyc();
  endtask

  initial begin
    rst = 1; clear_id();
    older_inflight = 0; ex_redirect = 0; mtvec = 32'h201; mepc = 32'h0;
    cyc(); cyc();
    rst = 0;
    settle();
    check_quiet("reset");
    check("reset_cnt", {16'd0, trap_cnt}, 32'd0);

    // Illegal instruction, empty pipe
    fire(1, 0, 0, 32'h100, 32'hFFFF_FFFF);
    settle();
    check("ill_c0_stall", {31'd0, stall_if_id}, 32'd1);
    check("ill_c0_busy",  {31'd0, busy}, 32'd0);
    cyc(); clear_id(); settle();
    check("ill_c1_stall", {31'd0, stall_if_id}, 32'd1);
    check("ill_c1_busy",  {31'd0, busy}, 32'd1);
    check("ill_c1_twe",   {31'd0, csr_trap_we}, 32'd0);
    cyc(); settle();
    check("ill_c2_stall",  {31'd0, stall_if_id}, 32'd1);
    check("ill_c2_twe",    {31'd0, csr_trap_we}, 32'd1);
    check("ill_c2_mepc",   csr_mepc_wdata, 32'h100);
    check("ill_c2_mcause", csr_mcause_wdata, 32'd2);
    check("ill_c2_mtval",  csr_mtval_wdata, 32'hFFFF_FFFF);
    check("ill_c2_mwe",    {31'd0, csr_mret_we}, 32'd0);
    cyc(); settle();
    check("ill_c3_rv",    {31'd0, redirect_valid}, 32'd1);
    check("ill_c3_rpc",   redirect_pc, 32'h200);
    check("ill_c3_flush", {31'd0, flush_id}, 32'd1);
    check("ill_c3_stall", {31'd0, stall_if_id}, 32'd0);
    check("ill_c3_twe",   {31'd0, csr_trap_we}, 32'd0);
    check("ill_cnt",      {16'd0, trap_cnt}, 32'd1);
    cyc(); settle();
    check_quiet("ill_c4");

    // Ecall with three cycles of drain
    older_inflight = 1;
    fire(0, 1, 0, 32'h40, 32'h73);
    cyc(); clear_id();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) older_inflight = 0;
      settle();
      check("ec_drain_busy", {31'd0, busy}, 32'd1);
      check("ec_drain_twe",  {31'd0, csr_trap_we}, 32'd0);
      check("ec_drain_rv",   {31'd0, redirect_valid}, 32'd0);
      cyc();
    end
    settle();
    check("ec_twe",    {31'd0, csr_trap_we}, 32'd1);
    check("ec_mepc",   csr_mepc_wdata, 32'h40);
    check("ec_mcause", csr_mcause_wdata, 32'd11);
    check("ec_mtval",  csr_mtval_wdata, 32'd0);
    cyc(); settle();
    check("ec_rv",  {31'd0, redirect_valid}, 32'd1);
    check("ec_rpc", redirect_pc, 32'h200);
    check("ec_cnt", {16'd0, trap_cnt}, 32'd2);
    cyc();

    // Mret
    mepc = 32'h88;
    fire(0, 0, 1, 32'h500, 32'h3020_0073);
    cyc(); clear_id(); cyc(); settle();
    check("mret_mwe",    {31'd0, csr_mret_we}, 32'd1);
    check("mret_twe",    {31'd0, csr_trap_we}, 32'd0);
    check("mret_wdata",  csr_mepc_wdata | csr_mcause_wdata | csr_mtval_wdata, 32'd0);
    cyc(); settle();
    check("mret_mwe_off", {31'd0, csr_mret_we}, 32'd0);
    check("mret_rv",      {31'd0, redirect_valid}, 32'd1);
    check("mret_rpc",     redirect_pc, 32'h88);
    check("mret_cnt",     {16'd0, trap_cnt}, 32'd2);
    cyc();

    // Squash A: redirect in the event cycle
    ex_redirect = 1;
    fire(1, 0, 0, 32'h600, 32'h0);
    settle();
    check("sqA_stall", {31'd0, stall_if_id}, 32'd0);
    cyc(); clear_id(); ex_redirect = 0; settle();
    check("sqA_busy", {31'd0, busy}, 32'd0);

    // Squash B: redirect during DRAIN
    older_inflight = 1;
    fire(0, 1, 0, 32'h700, 32'h0);
    cyc(); clear_id(); ex_redirect = 1; settle();
    check("sqB_flush", {31'd0, flush_id}, 32'd1);
    check("sqB_twe",   {31'd0, csr_trap_we}, 32'd0);
    check("sqB_mwe",   {31'd0, csr_mret_we}, 32'd0);
    cyc(); ex_redirect = 0; older_inflight = 0; settle();
    check_quiet("sqB_after");
    cyc(); settle();
    check("sqB_cnt", {16'd0, trap_cnt}, 32'd2);

    // Reset asserted in COMMIT
    fire(1, 0, 0, 32'h800, 32'h1234);
    cyc(); clear_id(); cyc(); settle();
    check("rstm_commit_twe", {31'd0, csr_trap_we}, 32'd1);
    rst = 1;
    cyc(); rst = 0; settle();
    check_quiet("rstm_after");
    check("rstm_cnt", {16'd0, trap_cnt}, 32'd0);

    // Priority: illegal and ecall together yields illegal cause
    fire(1, 1, 0, 32'h900, 32'hDEAD_BEEF);
    cyc(); clear_id(); cyc(); settle();
    check("prio_mcause", csr_mcause_wdata, 32'd2);
    check("prio_mtval",  csr_mtval_wdata, 32'hDEAD_BEEF);
    cyc(); cyc();

    // Four more traps: wide counter reaches 5, narrow one saturates at 3
    for (int i = 0; i < 4; i++) quick_trap(i[0], ~i[0]);
    settle();
    check("sat_wide_cnt",   {16'd0, trap_cnt}, 32'd5);
    check("sat_narrow_cnt", {30'd0, s_cnt}, 32'd3);
    check_quiet("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
Sequences precise exception entry and return for the decode stage of the 5-stage RV32I pipeline. It samples decode-stage status: illegal instruction, ecall and mret. It then holds IF/ID, waits for older instructions in EX/MEM/WB to retire, and issues one CSR trap write (mepc/mcause/mtval) or one mret restore. Finally it redirects fetch to mtvec or mepc and flushes ID. It sits between the ID control logic, the CSR file and the PC-select logic.

Parameters:
MCAUSE_ILLEGAL, 32'd2, mcause value for an illegal instruction
MCAUSE_ECALL, 32'd11, mcause value for an environment call from M-mode
CNT_W, 16, width of the saturating trap counter

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction (not a bubble, not flushed)
id_pc  in  32  PC of the ID instruction
id_ir  in  32  raw ID instruction word
is_illegal_ir  in  1  ID instruction is illegal
is_ecall  in  1  ID instruction is ecall
is_mret  in  1  ID instruction is mret
older_inflight  in  1  one or more valid instructions in EX/MEM/WB
ex_redirect  in  1  taken branch/jump resolved in EX this cycle
mtvec  in  32  current mtvec CSR value
mepc  in  32  current mepc CSR value
stall_if_id  out  1  hold PC and IF/ID register
flush_id  out  1  kill the ID instruction
redirect_valid  out  1  override next PC with redirect_pc
redirect_pc  out  32  fetch target
csr_trap_we  out  1  one-cycle write strobe for mepc/mcause/mtval
csr_mepc_wdata  out  32  trap PC
csr_mcause_wdata  out  32  trap cause
csr_mtval_wdata  out  32  trap value
csr_mret_we  out  1  one-cycle mret restore strobe
busy  out  1  FSM not in IDLE
trap_cnt  out  CNT_W  saturating count of committed traps (not mrets)

Behaviour:
- Reset: synchronous and active-high. When rst is 1 at a rising edge, the FSM goes to IDLE. Latched pc/ir/kind clear to 0 and trap_cnt clears to 0. Reset overrides every other input, including mid-sequence; no CSR strobe may be issued in the cycle after reset.
- Outputs in IDLE with no event: all outputs 0, except trap_cnt.
- Event: id_valid && !ex_redirect && (is_illegal_ir || is_ecall || is_mret).
  - Priority: illegal > ecall > mret.
  - ex_redirect in the same cycle means ID is on the wrong path; the event is ignored.
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE: on an event, latch id_pc, id_ir and kind {ILL, ECALL, MRET}, then go to DRAIN. stall_if_id=1 combinationally in the event cycle.
- DRAIN:
  - stall_if_id=1, busy=1.
  - If ex_redirect=1, an older branch squashes the trapping instruction: flush_id=1, go to IDLE, no CSR write, no count. ex_redirect has priority over older_inflight.
  - Else, if older_inflight=0, go to COMMIT; otherwise stay in DRAIN.
  - The minimum DRAIN duration is 1 cycle.
- COMMIT (exactly 1 cycle):
  - stall_if_id=1.
  - ILL: csr_trap_we=1, mepc=latched pc, mcause=MCAUSE_ILLEGAL, mtval=latched ir.
  - ECALL: csr_trap_we=1, mepc=latched pc, mcause=MCAUSE_ECALL, mtval=0.
  - MRET: csr_mret_we=1, csr_trap_we=0.
  - Go to REDIRECT.
  - trap_cnt increments on the edge leaving COMMIT for ILL/ECALL only, saturating at all-ones.
- REDIRECT (exactly 1 cycle):
  - redirect_valid=1, flush_id=1, stall_if_id=0.
  - redirect_pc = {mtvec[31:2],2'b00} for ILL/ECALL, or {mepc[31:2],2'b00} for MRET. Both are sampled in this cycle, so they reflect the write made in COMMIT.
  - Go to IDLE.
- Event-to-redirect latency: 3 cycles when older_inflight is already 0 (event, DRAIN, COMMIT, then redirect in the 4th cycle).
- The ID inputs are ignored outside IDLE. A new event is accepted no earlier than the cycle after REDIRECT.
- csr_*_wdata are 0 whenever csr_trap_we=0.
- busy=1 in DRAIN, COMMIT and REDIRECT.

Test Plan:
- Illegal, empty pipe:
  - Stimulus: id_pc=0x100, id_ir=0xFFFFFFFF, is_illegal_ir=1, older_inflight=0, mtvec=0x201.
  - Response: stall in cycles 0-2; cycle 2 csr_trap_we=1, mepc=0x100, mcause=2, mtval=0xFFFFFFFF; cycle 3 redirect_pc=0x200, flush_id=1; trap_cnt=1.
- Ecall with drain:
  - Stimulus: id_pc=0x40, is_ecall=1, older_inflight=1 for 3 cycles.
  - Response: DRAIN held 3 cycles; mcause=11, mtval=0; redirect follows the COMMIT cycle.
- Mret:
  - Stimulus: is_mret=1, mepc=0x88.
  - Response: csr_mret_we=1 for exactly 1 cycle, csr_trap_we=0; redirect_pc=0x88; trap_cnt unchanged.
- Squash:
  - Stimulus A: ex_redirect=1 in the event cycle.
    - Response A: FSM stays in IDLE, no stall.
  - Stimulus B: ex_redirect=1 during DRAIN.
    - Response B: flush_id=1 and return to IDLE; no CSR strobe; trap_cnt unchanged.
- Reset mid-sequence:
  - Stimulus: assert rst in COMMIT.
  - Response: next cycle all outputs 0, trap_cnt=0, no redirect.
- Saturation and priority:
  - Stimulus: CNT_W=2 with 5 traps; separately, is_illegal_ir=1 and is_ecall=1 together.
  - Response: trap_cnt stops at 3; the simultaneous case yields mcause=2.
